// File: rtl/dram_port_arbiter.sv
// Two-requester front end for the single-port dram macro: round-robin grant with bounded burst hold,
// one registered command stage, and read-return routing. `DRAM_ARB_FIXED_PRIO_EN gives requester 0 strict priority.
module dram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  tb_rst,

  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [BE_WIDTH-1:0]   r0_be,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,

  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic [BE_WIDTH-1:0]   r1_be,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned TAG_LAST = RD_LATENCY - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic gnt0_c, gnt1_c, accept_c, burst_full_c;

  logic                  sel_we_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic [BE_WIDTH-1:0]   sel_be_c;

  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_wr_en_q;
  logic [DATA_WIDTH-1:0] ram_wr_data_q;
  logic [BE_WIDTH-1:0]   ram_wr_byte_en_q;

  // Tag = {is_read, requester id}; one entry per cycle of RAM read latency.
  logic [1:0] tag_q [RD_LATENCY];
  logic       r0_rvalid_q, r1_rvalid_q;

  // Arbitration state register
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Grant selection and next-state
  always_comb begin
    gnt0_c       = 1'b0;
    gnt1_c       = 1'b0;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    burst_full_c = (burst_cnt_q >= CNT_W'(MAX_BURST));

`ifdef DRAM_ARB_FIXED_PRIO_EN
    gnt0_c = r0_valid;
    gnt1_c = r1_valid & ~r0_valid;
`else
    case (state_q)
      OWN0: begin
        if (r0_valid && (!r1_valid || !burst_full_c)) gnt0_c = 1'b1;
        else                                          gnt1_c = r1_valid;
      end
      OWN1: begin
        if (r1_valid && (!r0_valid || !burst_full_c)) gnt1_c = 1'b1;
        else                                          gnt0_c = r0_valid;
      end
      default: begin
        if (r0_valid && r1_valid) begin
          gnt0_c = last_grant_q;
          gnt1_c = ~last_grant_q;
        end else begin
          gnt0_c = r0_valid;
          gnt1_c = r1_valid;
        end
      end
    endcase
`endif

    // Nothing may be accepted while reset is held.
    if (tb_rst) begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
    end

    if (gnt0_c) begin
      state_d      = OWN0;
      last_grant_d = 1'b0;
      if (state_q == OWN0) burst_cnt_d = burst_full_c ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
      else                 burst_cnt_d = CNT_W'(1);
    end else if (gnt1_c) begin
      state_d      = OWN1;
      last_grant_d = 1'b1;
      if (state_q == OWN1) burst_cnt_d = burst_full_c ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
      else                 burst_cnt_d = CNT_W'(1);
    end else begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end
  end

  assign accept_c    = gnt0_c | gnt1_c;
  assign sel_we_c    = gnt1_c ? r1_we    : r0_we;
  assign sel_addr_c  = gnt1_c ? r1_addr  : r0_addr;
  assign sel_wdata_c = gnt1_c ? r1_wdata : r0_wdata;
  assign sel_be_c    = gnt1_c ? r1_be    : r0_be;

  // RAM command stage; address and data hold between accepts
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      ram_addr_q       <= '0;
      ram_wr_en_q      <= 1'b0;
      ram_wr_data_q    <= '0;
      ram_wr_byte_en_q <= '0;
    end else if (accept_c) begin
      ram_addr_q       <= sel_addr_c;
      ram_wr_en_q      <= sel_we_c;
      ram_wr_data_q    <= sel_wdata_c;
      ram_wr_byte_en_q <= sel_we_c ? sel_be_c : '0;
    end else begin
      ram_wr_en_q      <= 1'b0;
      ram_wr_byte_en_q <= '0;
    end
  end

  // Read-tag pipeline and return pulses
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      tag_q[0] <= {accept_c & ~sel_we_c, gnt1_c};
      for (int unsigned i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      r0_rvalid_q <= tag_q[TAG_LAST][1] & ~tag_q[TAG_LAST][0];
      r1_rvalid_q <= tag_q[TAG_LAST][1] &  tag_q[TAG_LAST][0];
    end
  end

  assign r0_ready       = gnt0_c;
  assign r1_ready       = gnt1_c;
  assign r0_rvalid      = r0_rvalid_q;
  assign r1_rvalid      = r1_rvalid_q;
  assign r0_rdata       = ram_rd_data;
  assign r1_rdata       = ram_rd_data;
  assign ram_addr       = ram_addr_q;
  assign ram_wr_en      = ram_wr_en_q;
  assign ram_wr_data    = ram_wr_data_q;
  assign ram_wr_byte_en = ram_wr_byte_en_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: two instances (read latency 1 and 2) share stimulus, each with a RAM model,
// checked against a transaction-level arbitration/memory reference.
module tb_dram_port_arbiter;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int          MB = 8;
  localparam int          NWORDS = 1 << AW;

  logic clk = 1'b0;
  logic tb_rst;
  always #5 clk = ~clk;

  logic          v0, v1, we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic [BW-1:0] b0, b1;

  logic          rdy0 [2], rdy1 [2], rv0 [2], rv1 [2], wen [2];
  logic [DW-1:0] rd0 [2], rd1 [2], wdat [2], rram [2];
  logic [AW-1:0] radr [2];
  logic [BW-1:0] rbe [2];

  for (genvar L = 0; L < 2; L++) begin : g_inst
    logic [DW-1:0] mem [NWORDS];
    logic [DW-1:0] q1, q2;

    dram_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
      .RD_LATENCY(L + 1), .MAX_BURST(MB)
    ) u_dut (
      .clk(clk), .tb_rst(tb_rst),
      .r0_valid(v0), .r0_ready(rdy0[L]), .r0_we(we0), .r0_addr(a0), .r0_wdata(d0), .r0_be(b0),
      .r0_rvalid(rv0[L]), .r0_rdata(rd0[L]),
      .r1_valid(v1), .r1_ready(rdy1[L]), .r1_we(we1), .r1_addr(a1), .r1_wdata(d1), .r1_be(b1),
      .r1_rvalid(rv1[L]), .r1_rdata(rd1[L]),
      .ram_addr(radr[L]), .ram_wr_en(wen[L]), .ram_wr_data(wdat[L]),
      .ram_wr_byte_en(rbe[L]), .ram_rd_data(rram[L])
    );

    // Single-port RAM: byte-enabled write, read data after 1 or 2 edges
    always @(posedge clk) begin
      if (wen[L])
        for (int k = 0; k < BW; k++)
          if (rbe[L][k]) mem[radr[L]][8*k +: 8] <= wdat[L][8*k +: 8];
      q1 <= mem[radr[L]];
      q2 <= q1;
    end
    assign rram[L] = (L == 0) ? q1 : q2;
  end

  int checks, errors, cyc;
  int m_own, m_run, m_last;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_mem [NWORDS];
  bit            pend_v  [2][8];
  bit            pend_id [2][8];
  logic [DW-1:0] pend_d  [2][8];
  int            rv_cnt  [2][2];
  logic [DW-1:0] last_rd [2][2];
  int            rd_acc  [2];

  // Who should win this cycle, from the arbitration rules
  function automatic int exp_grant();
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    return 0;
`else
    if (m_own < 0) return 1 - m_last;
    if (m_run < MB) return m_own;
    return 1 - m_own;
`endif
  endfunction

  task automatic model_reset();
    m_own = -1; m_run = 0; m_last = 1;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    for (int L = 0; L < 2; L++)
      for (int s = 0; s < 8; s++) pend_v[L][s] = 1'b0;
  endtask

  // One clock: compare grant, command stage and read returns, then advance the reference
  task automatic tick(output int g);
    logic wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd, mask;
    logic [BW-1:0] be;
    int s;
    #1;
    g = exp_grant();
    s = cyc % 8;
    for (int L = 0; L < 2; L++) begin
      checks++;
      if (rdy0[L] !== (g == 0) || rdy1[L] !== (g == 1)) begin
        errors++;
        $display("FAIL ready lat%0d cyc %0d: got r0=%b r1=%b, want grant %0d", L+1, cyc, rdy0[L], rdy1[L], g);
      end
      checks++;
      if (wen[L] !== m_we || radr[L] !== m_addr || wdat[L] !== m_wdata || rbe[L] !== m_be) begin
        errors++;
        $display("FAIL ram_cmd lat%0d cyc %0d: got en=%b a=%h d=%h be=%h, want en=%b a=%h d=%h be=%h",
                 L+1, cyc, wen[L], radr[L], wdat[L], rbe[L], m_we, m_addr, m_wdata, m_be);
      end
      checks++;
      if (rv0[L] !== (pend_v[L][s] && !pend_id[L][s]) || rv1[L] !== (pend_v[L][s] && pend_id[L][s])) begin
        errors++;
        $display("FAIL rvalid lat%0d cyc %0d: got rv0=%b rv1=%b, want valid=%b id=%b",
                 L+1, cyc, rv0[L], rv1[L], pend_v[L][s], pend_id[L][s]);
      end
      if (pend_v[L][s]) begin
        checks++;
        if ((pend_id[L][s] ? rd1[L] : rd0[L]) !== pend_d[L][s]) begin
          errors++;
          $display("FAIL rdata lat%0d cyc %0d: got %h, want %h", L+1, cyc,
                   pend_id[L][s] ? rd1[L] : rd0[L], pend_d[L][s]);
        end
      end
      if (rv0[L] === 1'b1) begin rv_cnt[L][0]++; last_rd[L][0] = rd0[L]; end
      if (rv1[L] === 1'b1) begin rv_cnt[L][1]++; last_rd[L][1] = rd1[L]; end
      pend_v[L][s] = 1'b0;
    end
    @(posedge clk);
    cyc++;
    if (g < 0) begin
      m_we = 1'b0; m_be = '0; m_own = -1;
    end else begin
      wr = (g == 0) ? we0 : we1;
      ad = (g == 0) ? a0  : a1;
      wd = (g == 0) ? d0  : d1;
      be = (g == 0) ? b0  : b1;
      m_addr = ad; m_wdata = wd; m_we = wr; m_be = wr ? be : '0;
      if (wr) begin
        for (int k = 0; k < BW; k++) mask[8*k +: 8] = {8{be[k]}};
        m_mem[ad] = (m_mem[ad] & ~mask) | (wd & mask);
      end else begin
        rd_acc[g]++;
        for (int L = 0; L < 2; L++) begin
          s = (cyc + L + 1) % 8;
          pend_v[L][s] = 1'b1; pend_id[L][s] = (g == 1); pend_d[L][s] = m_mem[ad];
        end
      end
      m_run  = (g == m_own) ? ((m_run < MB) ? m_run + 1 : m_run) : 1;
      m_own  = g;
      m_last = g;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    int g;
    v0 = 1'b0; v1 = 1'b0;
    repeat (n) tick(g);
  endtask

  task automatic test_reset();
    tb_rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int L = 0; L < 2; L++) begin
      checks++;
      if (rdy0[L] !== 1'b0 || rdy1[L] !== 1'b0) begin
        errors++; $display("FAIL reset_ready lat%0d: got %b%b, want 00", L+1, rdy1[L], rdy0[L]);
      end
      checks++;
      if (wen[L] !== 1'b0 || radr[L] !== '0 || wdat[L] !== '0 || rbe[L] !== '0) begin
        errors++; $display("FAIL reset_ram lat%0d: got en=%b a=%h d=%h be=%h, want all 0", L+1, wen[L], radr[L], wdat[L], rbe[L]);
      end
      checks++;
      if (rv0[L] !== 1'b0 || rv1[L] !== 1'b0) begin
        errors++; $display("FAIL reset_rvalid lat%0d: got %b%b, want 00", L+1, rv1[L], rv0[L]);
      end
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; tb_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_write();
    int g, c0 [2], c1 [2];
    for (int L = 0; L < 2; L++) begin c0[L] = rv_cnt[L][0]; c1[L] = rv_cnt[L][1]; end
    v0 = 1'b1; we0 = 1'b1; a0 = AW'(5); d0 = 32'hDEADBEEF; b0 = 4'hF;
    tick(g);
    v0 = 1'b0;
    v1 = 1'b1; we1 = 1'b0; a1 = AW'(5); d1 = $urandom; b1 = 4'($urandom);
    tick(g);
    drain(4);
    for (int L = 0; L < 2; L++) begin
      checks++;
      if (rv_cnt[L][1] - c1[L] !== 1 || rv_cnt[L][0] - c0[L] !== 0) begin
        errors++; $display("FAIL single_pulses lat%0d: got r1=%0d r0=%0d, want 1 0", L+1, rv_cnt[L][1]-c1[L], rv_cnt[L][0]-c0[L]);
      end
      checks++;
      if (last_rd[L][1] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL single_data lat%0d: got %h, want deadbeef", L+1, last_rd[L][1]);
      end
    end
  endtask

  task automatic test_byte_enable();
    int g;
    v0 = 1'b1; we0 = 1'b1; a0 = AW'(16); d0 = 32'hFFFFFFFF; b0 = 4'hF;
    tick(g);
    d0 = 32'h00000000; b0 = 4'b0101;
    tick(g);
    we0 = 1'b0;
    tick(g);
    drain(4);
    for (int L = 0; L < 2; L++) begin
      checks++;
      if (last_rd[L][0] !== 32'hFF00FF00) begin
        errors++; $display("FAIL byte_enable lat%0d: got %h, want ff00ff00", L+1, last_rd[L][0]);
      end
    end
  endtask

  task automatic test_sweep();
    int g, e0, c1 [2];
    e0 = errors;
    for (int L = 0; L < 2; L++) c1[L] = rv_cnt[L][1];
    v0 = 1'b1; we0 = 1'b1; b0 = 4'hF;
    for (int i = 0; i < NWORDS; i++) begin
      a0 = AW'(i); d0 = 32'hFFFFFFFF - 32'(i);
      tick(g);
    end
    v0 = 1'b0;
    v1 = 1'b1; we1 = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      a1 = AW'(i);
      tick(g);
    end
    drain(4);
    for (int L = 0; L < 2; L++) begin
      checks++;
      if (rv_cnt[L][1] - c1[L] !== NWORDS || last_rd[L][1] !== 32'hFFFF8000) begin
        errors++; $display("FAIL sweep_count lat%0d: got %0d last %h, want %0d last ffff8000", L+1, rv_cnt[L][1]-c1[L], last_rd[L][1], NWORDS);
      end
    end
    checks++;
    if (errors !== e0) begin
      errors++; $display("FAIL sweep_errors: got %0d new errors, want 0", errors - e0);
    end
  endtask

  task automatic test_contention();
    int g, n0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    localparam int N = 20, WANT0 = 20;
`else
    localparam int N = 32, WANT0 = 16;
`endif
    drain(2);
    n0 = 0;
    v0 = 1'b1; v1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    a0 = AW'($urandom); a1 = AW'($urandom);
    for (int c = 0; c < N; c++) begin
      #1;
      for (int L = 0; L < 2; L++) begin
        checks++;
        if ((rdy0[L] ^ rdy1[L]) !== 1'b1) begin
          errors++; $display("FAIL contention_one lat%0d cyc %0d: got r0=%b r1=%b, want exactly one", L+1, cyc, rdy0[L], rdy1[L]);
        end
      end
      if (rdy0[0] === 1'b1) n0++;
      tick(g);
      if (g == 0) a0 = AW'($urandom);
      if (g == 1) a1 = AW'($urandom);
    end
    drain(4);
    checks++;
    if (n0 !== WANT0) begin
      errors++; $display("FAIL contention_share: got %0d r0 accepts of %0d, want %0d", n0, N, WANT0);
    end
  endtask

  task automatic test_random();
    int g, h0, h1, acc0 [2], c [2][2];
    h0 = 0; h1 = 0;
    acc0[0] = rd_acc[0]; acc0[1] = rd_acc[1];
    for (int L = 0; L < 2; L++) begin c[L][0] = rv_cnt[L][0]; c[L][1] = rv_cnt[L][1]; end
    for (int n = 0; n < 1500; n++) begin
      if (h0 == 0) begin
        v0 = ($urandom % 10) < 7;
        we0 = 1'($urandom); a0 = AW'($urandom % 16); d0 = $urandom; b0 = 4'($urandom);
        h0 = v0;
      end
      if (h1 == 0) begin
        v1 = ($urandom % 10) < 7;
        we1 = 1'($urandom); a1 = AW'($urandom % 16); d1 = $urandom; b1 = 4'($urandom);
        h1 = v1;
      end
      tick(g);
      if (g == 0) h0 = 0;
      if (g == 1) h1 = 0;
    end
    drain(4);
    for (int L = 0; L < 2; L++) begin
      checks++;
      if (rv_cnt[L][0] - c[L][0] !== rd_acc[0] - acc0[0] || rv_cnt[L][1] - c[L][1] !== rd_acc[1] - acc0[1]) begin
        errors++; $display("FAIL random_counts lat%0d: got %0d/%0d pulses, want %0d/%0d", L+1,
                           rv_cnt[L][0]-c[L][0], rv_cnt[L][1]-c[L][1], rd_acc[0]-acc0[0], rd_acc[1]-acc0[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int g;
    drain(2);
    v1 = 1'b1; we1 = 1'b0; a1 = AW'(5);
    tick(g);
    a1 = AW'(16);
    tick(g);
    v0 = 1'b1; we0 = 1'b0; a0 = AW'(3);
    tb_rst = 1'b1;
    #1;
    for (int L = 0; L < 2; L++) begin
      checks++;
      if (rv0[L] !== 1'b0 || rv1[L] !== 1'b0 || wen[L] !== 1'b0 || radr[L] !== '0 || rdy0[L] !== 1'b0 || rdy1[L] !== 1'b0) begin
        errors++; $display("FAIL midreset lat%0d: got rv=%b%b en=%b a=%h rdy=%b%b, want all 0",
                           L+1, rv1[L], rv0[L], wen[L], radr[L], rdy1[L], rdy0[L]);
      end
    end
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int L = 0; L < 2; L++) begin
        checks++;
        if (rv0[L] !== 1'b0 || rv1[L] !== 1'b0) begin
          errors++; $display("FAIL midreset_rvalid lat%0d: got %b%b, want 00", L+1, rv1[L], rv0[L]);
        end
      end
    end
    @(negedge clk);
    tb_rst = 1'b0;
    #1;
    for (int L = 0; L < 2; L++) begin
      checks++;
      if (rdy0[L] !== 1'b1 || rdy1[L] !== 1'b0) begin
        errors++; $display("FAIL first_grant lat%0d: got r0=%b r1=%b, want r0", L+1, rdy0[L], rdy1[L]);
      end
    end
    tick(g);
    drain(6);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    tb_rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; b0 = '0; b1 = '0;
    for (int L = 0; L < 2; L++) begin
      rv_cnt[L][0] = 0; rv_cnt[L][1] = 0; last_rd[L][0] = '0; last_rd[L][1] = '0;
    end
    rd_acc[0] = 0; rd_acc[1] = 0;
    model_reset();
    test_reset();
    test_single_write();
    test_byte_enable();
    test_sweep();
    test_contention();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
